bpu_predecode: RTL and testbench
================================

BPU_PREDECODE -- requirements
Module: bpu_predecode

Interface
REQ-001 SHALL have parameter BTB_NUM, default 16, number of indirect-jump BTB entries (power of two, >=2).
REQ-002 SHALL have parameter BHR_W, default 6, global history width; PHT has 2^BHR_W entries.
REQ-003 SHALL have parameter RAS_DEPTH, default 8, return-address-stack entries (power of two).
REQ-004 SHALL have ports:
 clk  in  1  single clock, rising edge
 rstn  in  1  reset, asynchronous, active-low
 in_valid  in  1  fetch slot valid
 in_pc  in  32  fetch PC
 in_inst  in  32  fetch instruction
 in_allowin  out  1  stage can accept
 out_allowin  in  1  decode can accept
 out_valid  out  1  stage output valid
 out_pc  out  32  registered PC
 out_inst  out  32  registered instruction
 pred_taken  out  1  predicted taken
 pred_target  out  32  predicted target, 0 when not taken
 flush  in  1  kill stage contents (mispredict/exception/ertn)
 upd_valid  in  1  commit-time update strobe
 upd_pc  in  32  committed branch PC
 upd_cond  in  1  committed instr is beq/bne/blt/bge/bltu/bgeu
 upd_jirl  in  1  committed instr is jirl
 upd_taken  in  1  actual direction
 upd_target  in  32  actual target

Function
REQ-005 Stage register: in_allowin = !valid_r | out_allowin; on in_valid & in_allowin capture pc/inst and set valid_r; on in_allowin & !in_valid clear valid_r.
REQ-006 out_valid = valid_r; prediction outputs combinational from registered pc/inst, zero extra latency; no stall ever generated.
REQ-007 flush clears valid_r next edge and overrides capture; RAS and tables unaffected.
REQ-008 Decode (inst[31:26]): 0x13 jirl, 0x14 b, 0x15 bl, 0x16-0x1b conditional.
REQ-009 b/bl: taken=1, target = pc + sext({inst[9:0],inst[25:10],2'b00}), 32-bit wrap.
REQ-010 Conditional: taken = PHT[idx][1], idx = GHR ^ pc[BHR_W+1:2]; target = pc + sext({inst[25:10],2'b00}) when taken.
REQ-011 jirl with rd(inst[4:0])==0 and rj(inst[9:5])==1 is a return: if RAS non-empty taken=1, target=RAS top; else falls to REQ-012.
REQ-012 Other jirl: BTB fully associative on pc[31:2]; hit -> taken=1, target=entry target; miss -> taken=0.
REQ-013 Non-branch or !valid_r: pred_taken=0, pred_target=0.
REQ-014 RAS push (pc+4) when bl fires (out_valid & out_allowin); pop when predicted return fires; push at full overwrites oldest (circular pointer wraps, count saturates at RAS_DEPTH); pop at empty is no-op.
REQ-015 GHR: speculative shift-in of predicted direction when a conditional fires; on upd_valid & upd_cond & flush same cycle, GHR restored to committed history shifted with upd_taken.
REQ-016 PHT: on upd_valid & upd_cond, 2-bit saturating counter (00..11) at committed index (committed GHR ^ upd_pc[BHR_W+1:2]) incremented if taken else decremented; committed GHR shifts upd_taken.
REQ-017 BTB: on upd_valid & upd_jirl & upd_taken: hit -> overwrite target in place; miss -> write entry at round-robin pointer, pointer increments mod BTB_NUM.
REQ-018 Update and lookup in same cycle on same entry: lookup sees pre-update value.
REQ-019 All widths and indices derived from parameters; no literal table sizes.

Reset
REQ-020 rstn low asynchronously: valid_r=0, pc/inst=0, GHRs=0, RAS empty (ptr 0, count 0), BTB valid bits 0, BTB pointer 0, all PHT counters 2'b01; outputs therefore out_valid=0, pred_taken=0, pred_target=0.
REQ-021 Reset mid-operation discards in-flight instruction and all learned state.

Verification
REQ-022 b at pc 0x1C000000, offs26=+4 words -> pred_taken=1, pred_target=0x1C000010; offs26=-1 -> 0x1BFFFFFC.
REQ-023 Post-reset beq -> taken=0; two upd taken updates on same idx -> counter 11, next beq lookup taken=1, target pc+offs.
REQ-024 bl at 0x1C000100 fires then return jirl (rd=0,rj=1) -> target 0x1C000104; 9 bl with RAS_DEPTH=8 then 9 returns -> 8 correct targets, ninth uses BTB/not-taken.
REQ-025 BTB_NUM=4: 5 distinct jirl updates -> first entry evicted, lookups of entries 2-5 hit, entry 1 miss.
REQ-026 flush asserted with in_valid=1 and out_allowin=0 -> out_valid=0 next cycle; rstn pulsed mid-stream -> all outputs 0 immediately, before next clk edge.

Source files
------------

// File: rtl/bpu_predecode.sv
// Fetch-to-decode pre-decode stage with branch prediction: gshare PHT for
// conditionals, return-address stack for returns, fully associative BTB for jirl.
module bpu_predecode #(
    parameter int BTB_NUM   = 16,
    parameter int BHR_W     = 6,
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        in_allowin,
    input  logic        out_allowin,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        flush,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_cond,
    input  logic        upd_jirl,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);
    localparam int PHT_N  = 1 << BHR_W;
    localparam int BTB_IW = $clog2(BTB_NUM);
    localparam int RAS_IW = $clog2(RAS_DEPTH);
    localparam int RAS_CW = RAS_IW + 1;
    localparam logic [RAS_CW-1:0] RAS_FULL = RAS_CW'(RAS_DEPTH);

    logic               valid_r;
    logic [31:0]        pc_r;
    logic [31:0]        inst_r;
    logic [BHR_W-1:0]   ghr_spec;
    logic [BHR_W-1:0]   ghr_commit;
    logic [1:0]         pht [PHT_N];
    logic [31:0]        ras [RAS_DEPTH];
    logic [RAS_IW-1:0]  ras_ptr;
    logic [RAS_CW-1:0]  ras_cnt;
    logic [BTB_NUM-1:0] btb_valid;
    logic [29:0]        btb_tag [BTB_NUM];
    logic [31:0]        btb_tgt [BTB_NUM];
    logic [BTB_IW-1:0]  btb_ptr;

    logic [5:0]         opcode;
    logic               is_jirl, is_b, is_bl, is_cond, is_ret;
    logic [31:0]        off_long, off_cond, ras_top;
    logic [BHR_W-1:0]   pht_idx, upd_idx;
    logic               btb_hit, upd_hit, use_ras, fire, btb_wr, cond_upd;
    logic [31:0]        btb_hit_tgt;
    logic [BTB_IW-1:0]  upd_hit_idx;
    logic               unused_bits;

    assign unused_bits = ^upd_pc[1:0];

    assign in_allowin = !valid_r | out_allowin;
    assign out_valid  = valid_r;
    assign out_pc     = pc_r;
    assign out_inst   = inst_r;
    assign fire       = valid_r & out_allowin;
    assign cond_upd   = upd_valid & upd_cond;
    assign btb_wr     = upd_valid & upd_jirl & upd_taken;

    assign opcode   = inst_r[31:26];
    assign is_jirl  = (opcode == 6'h13);
    assign is_b     = (opcode == 6'h14);
    assign is_bl    = (opcode == 6'h15);
    assign is_cond  = (opcode >= 6'h16) && (opcode <= 6'h1b);
    assign is_ret   = is_jirl && (inst_r[4:0] == 5'd0) && (inst_r[9:5] == 5'd1);
    assign off_long = {{4{inst_r[9]}}, inst_r[9:0], inst_r[25:10], 2'b00};
    assign off_cond = {{14{inst_r[25]}}, inst_r[25:10], 2'b00};
    assign ras_top  = ras[ras_ptr - 1'b1];
    assign pht_idx  = ghr_spec ^ pc_r[BHR_W+1:2];
    assign upd_idx  = ghr_commit ^ upd_pc[BHR_W+1:2];

    // Lowest matching entry wins; duplicates cannot arise since updates hit in place.
    always_comb begin
        btb_hit     = 1'b0;
        btb_hit_tgt = '0;
        upd_hit     = 1'b0;
        upd_hit_idx = '0;
        for (int i = 0; i < BTB_NUM; i++) begin
            if (!btb_hit && btb_valid[i] && btb_tag[i] == pc_r[31:2]) begin
                btb_hit     = 1'b1;
                btb_hit_tgt = btb_tgt[i];
            end
            if (!upd_hit && btb_valid[i] && btb_tag[i] == upd_pc[31:2]) begin
                upd_hit     = 1'b1;
                upd_hit_idx = BTB_IW'(i);
            end
        end
    end

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = '0;
        use_ras     = 1'b0;
        if (valid_r) begin
            if (is_b || is_bl) begin
                pred_taken  = 1'b1;
                pred_target = pc_r + off_long;
            end else if (is_cond) begin
                if (pht[pht_idx][1]) begin
                    pred_taken  = 1'b1;
                    pred_target = pc_r + off_cond;
                end
            end else if (is_jirl) begin
                if (is_ret && ras_cnt != '0) begin
                    pred_taken  = 1'b1;
                    pred_target = ras_top;
                    use_ras     = 1'b1;
                end else if (btb_hit) begin
                    pred_taken  = 1'b1;
                    pred_target = btb_hit_tgt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r <= 1'b0;
            pc_r    <= '0;
            inst_r  <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (in_allowin) begin
            valid_r <= in_valid;
            if (in_valid) begin
                pc_r   <= in_pc;
                inst_r <= in_inst;
            end
        end
    end

    // A mispredict flush paired with a commit rebuilds speculative history from the committed one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ghr_spec   <= '0;
            ghr_commit <= '0;
        end else begin
            if (cond_upd)
                ghr_commit <= {ghr_commit[BHR_W-2:0], upd_taken};
            if (flush && cond_upd)
                ghr_spec <= {ghr_commit[BHR_W-2:0], upd_taken};
            else if (fire && is_cond)
                ghr_spec <= {ghr_spec[BHR_W-2:0], pred_taken};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < PHT_N; i++)
                pht[i] <= 2'b01;
        end else if (cond_upd) begin
            if (upd_taken && pht[upd_idx] != 2'b11)
                pht[upd_idx] <= pht[upd_idx] + 2'b01;
            else if (!upd_taken && pht[upd_idx] != 2'b00)
                pht[upd_idx] <= pht[upd_idx] - 2'b01;
        end
    end

    // Circular stack: a push when full overwrites the oldest slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (fire && is_bl) begin
            ras_ptr <= ras_ptr + 1'b1;
            if (ras_cnt != RAS_FULL)
                ras_cnt <= ras_cnt + 1'b1;
        end else if (fire && use_ras) begin
            ras_ptr <= ras_ptr - 1'b1;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fire && is_bl)
            ras[ras_ptr] <= pc_r + 32'd4;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btb_valid <= '0;
            btb_ptr   <= '0;
        end else if (btb_wr && !upd_hit) begin
            btb_valid[btb_ptr] <= 1'b1;
            btb_ptr            <= btb_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_wr) begin
            if (upd_hit) begin
                btb_tgt[upd_hit_idx] <= upd_target;
            end else begin
                btb_tag[btb_ptr] <= upd_pc[31:2];
                btb_tgt[btb_ptr] <= upd_target;
            end
        end
    end
endmodule

// File: tb/tb_bpu_predecode.sv
// Scoreboard bench for bpu_predecode: expected predictions are queued when an
// instruction is driven and compared when it leaves the stage.
module tb_bpu_predecode;
    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, out_allowin, flush;
    logic [31:0] in_pc, in_inst;
    logic        in_allowin, out_valid, pred_taken;
    logic [31:0] out_pc, out_inst, pred_target;
    logic        upd_valid, upd_cond, upd_jirl, upd_taken;
    logic [31:0] upd_pc, upd_target;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [31:0] target;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    bpu_predecode #(.BTB_NUM(4), .BHR_W(6), .RAS_DEPTH(8)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_allowin(in_allowin),
        .out_allowin(out_allowin), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_cond(upd_cond), .upd_jirl(upd_jirl),
        .upd_taken(upd_taken), .upd_target(upd_target)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] encLong(input logic [5:0] op, input logic [25:0] offs);
        return {op, offs[15:0], offs[25:16]};
    endfunction

    function automatic logic [31:0] encCond(input logic [5:0] op, input logic [15:0] offs);
        return {op, offs, 5'd4, 5'd5};
    endfunction

    function automatic logic [31:0] encJirl(input logic [4:0] rj, input logic [4:0] rd);
        return {6'h13, 16'h0000, rj, rd};
    endfunction

    task automatic applyStimulus(input string name, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic taken, input logic [31:0] target);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        e.name = name; e.pc = pc; e.inst = inst; e.taken = taken; e.target = target;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic applyUpdate(input logic [31:0] pc, input logic cond, input logic jirl,
                               input logic taken, input logic [31:0] target, input logic with_flush);
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = pc; upd_cond = cond; upd_jirl = jirl;
        upd_taken = taken; upd_target = target; flush = with_flush;
        @(negedge clk);
        upd_valid = 1'b0; upd_cond = 1'b0; upd_jirl = 1'b0; upd_taken = 1'b0; flush = 1'b0;
    endtask

    // Every instruction leaving the stage is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (rstn && out_valid && out_allowin) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput({mon_e.name, ".pc"}, out_pc, mon_e.pc);
                checkOutput({mon_e.name, ".inst"}, out_inst, mon_e.inst);
                checkOutput({mon_e.name, ".taken"}, {31'd0, pred_taken}, {31'd0, mon_e.taken});
                checkOutput({mon_e.name, ".target"}, pred_target, mon_e.target);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_allowin = 1'b1; flush = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_cond = 1'b0; upd_jirl = 1'b0; upd_taken = 1'b0; upd_target = '0;
        #12;
        checkOutput("rst.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst.pred_taken", {31'd0, pred_taken}, 32'd0);
        checkOutput("rst.pred_target", pred_target, 32'd0);
        checkOutput("rst.out_pc", out_pc, 32'd0);
        checkOutput("rst.in_allowin", {31'd0, in_allowin}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;

        applyStimulus("b_fwd", 32'h1C000000, encLong(6'h14, 26'd4), 1'b1, 32'h1C000010);
        applyStimulus("b_back", 32'h1C000000, encLong(6'h14, 26'h3FFFFFF), 1'b1, 32'h1BFFFFFC);
        applyStimulus("nonbr", 32'h1C000008, 32'h02800000, 1'b0, 32'd0);
        applyStimulus("op1c", 32'h1C00000C, encCond(6'h1c, 16'd8), 1'b0, 32'd0);

        applyStimulus("beq_cold", 32'h1C000200, encCond(6'h16, 16'd8), 1'b0, 32'd0);
        applyUpdate(32'h1C000200, 1'b1, 1'b0, 1'b1, 32'h1C000220, 1'b0);
        applyUpdate(32'h1C000204, 1'b1, 1'b0, 1'b1, 32'h1C000220, 1'b0);
        applyStimulus("beq_warm", 32'h1C000200, encCond(6'h16, 16'd8), 1'b1, 32'h1C000220);
        applyUpdate(32'h1C000240, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus("bgeu_restored", 32'h1C000218, encCond(6'h1b, 16'd8), 1'b1, 32'h1C000238);

        applyStimulus("bl", 32'h1C000100, encLong(6'h15, 26'h40), 1'b1, 32'h1C000200);
        applyStimulus("ret", 32'h1C000300, encJirl(5'd1, 5'd0), 1'b1, 32'h1C000104);
        for (int i = 0; i < 9; i++)
            applyStimulus($sformatf("bl%0d", i), 32'h1C001000 + 32'(i * 16), encLong(6'h15, 26'd1),
                          1'b1, 32'h1C001004 + 32'(i * 16));
        for (int i = 8; i >= 1; i--)
            applyStimulus($sformatf("ret%0d", i), 32'h1C000300, encJirl(5'd1, 5'd0),
                          1'b1, 32'h1C001004 + 32'(i * 16));
        applyStimulus("ret_empty", 32'h1C000300, encJirl(5'd1, 5'd0), 1'b0, 32'd0);

        for (int k = 1; k <= 5; k++)
            applyUpdate(32'h1C002000 + 32'(4 * k), 1'b0, 1'b1, 1'b1, 32'h1C008000 + 32'(256 * k), 1'b0);
        applyStimulus("btb_evicted", 32'h1C002004, encJirl(5'd2, 5'd1), 1'b0, 32'd0);
        for (int k = 2; k <= 5; k++)
            applyStimulus($sformatf("btb%0d", k), 32'h1C002000 + 32'(4 * k), encJirl(5'd2, 5'd1),
                          1'b1, 32'h1C008000 + 32'(256 * k));
        applyUpdate(32'h1C00200C, 1'b0, 1'b1, 1'b1, 32'h1C00F000, 1'b0);
        applyStimulus("btb_rewrite", 32'h1C00200C, encJirl(5'd2, 5'd1), 1'b1, 32'h1C00F000);
        applyStimulus("btb_kept", 32'h1C002008, encJirl(5'd2, 5'd1), 1'b1, 32'h1C008200);

        @(negedge clk);
        out_allowin = 1'b0; in_valid = 1'b1; in_pc = 32'h1C000400; in_inst = encLong(6'h14, 26'd4);
        @(negedge clk);
        checkOutput("hold.out_valid", {31'd0, out_valid}, 32'd1);
        in_inst = encLong(6'h14, 26'd8); flush = 1'b1;
        @(negedge clk);
        checkOutput("flush.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush.pred_taken", {31'd0, pred_taken}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_allowin = 1'b1;

        applyStimulus("pre_rst_bl", 32'h1C000500, encLong(6'h15, 26'd4), 1'b1, 32'h1C000510);
        #2 rstn = 1'b0;
        #1;
        checkOutput("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst.pred_taken", {31'd0, pred_taken}, 32'd0);
        checkOutput("midrst.pred_target", pred_target, 32'd0);
        checkOutput("midrst.out_pc", out_pc, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus("post_btb", 32'h1C002008, encJirl(5'd2, 5'd1), 1'b0, 32'd0);
        applyStimulus("post_beq", 32'h1C000200, encCond(6'h16, 16'd8), 1'b0, 32'd0);
        applyStimulus("post_ret", 32'h1C000300, encJirl(5'd1, 5'd0), 1'b0, 32'd0);

        repeat (3) @(negedge clk);
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
